// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-button debounce with press/release
// pulses, and the btn0+btn1 hold-to-reset sequencer that also stretches power-on reset.

module btn_db_lane #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic sync_in,
    output logic db,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    // Any cycle where the synchronised level agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        db_d    = db_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sync_in != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d    = sync_in;
                press_d = sync_in;
                rel_d   = ~sync_in;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign db    = db_q;
    assign press = press_q;
    assign rel   = rel_q;
endmodule

module btn_conditioner #(
    parameter int NUM_BTN           = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_HOLD_CYCLES = 50000000,
    parameter int RST_PULSE_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               sys_resetn,
    output logic               combo_hold
);
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_ASSERT = 2'd2;
    localparam logic [1:0] ST_REARM  = 2'd3;

    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

    logic [NUM_BTN-1:0] s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d = btn_raw;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        btn_db_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk    (clk),
            .resetn (resetn),
            .sync_in(s2_q[i]),
            .db     (btn_db[i]),
            .press  (btn_press[i]),
            .rel    (btn_release[i])
        );
    end

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          sys_resetn_q, sys_resetn_d;
    logic          combo_hold_q, combo_hold_d;
    logic          both_held, both_up;

    assign both_held = btn_db[0] & btn_db[1];
    assign both_up   = ~btn_db[0] & ~btn_db[1];

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        state_d = state_q;
        hcnt_d  = '0;
        pcnt_d  = '0;
        case (state_q)
            ST_WAIT:   if (both_held) state_d = ST_HOLD;
            ST_HOLD: begin
                if (!both_held)              state_d = ST_WAIT;
                else if (hcnt_q == HOLD_LAST) state_d = ST_ASSERT;
                else                         hcnt_d  = hcnt_q + 1'b1;
            end
            ST_ASSERT: begin
                if (pcnt_q == PULSE_LAST) state_d = ST_REARM;
                else                      pcnt_d  = pcnt_q + 1'b1;
            end
            ST_REARM:  if (both_up) state_d = ST_WAIT;
        endcase
        sys_resetn_d = (state_d != ST_ASSERT);
        combo_hold_d = (state_d == ST_HOLD);
    end

    // Reset lands in ASSERT so the power-on stretch reuses the combo pulse path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_ASSERT;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
            sys_resetn_q <= 1'b0;
            combo_hold_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            pcnt_q       <= pcnt_d;
            sys_resetn_q <= sys_resetn_d;
            combo_hold_q <= combo_hold_d;
        end
    end

    assign sys_resetn = sys_resetn_q;
    assign combo_hold = combo_hold_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/hold/pulse parameters.

module tb_btn_conditioner;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_db, btn_press, btn_release;
    logic          sys_resetn, combo_hold;

    int vecs = 0;
    int errs = 0;

    btn_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(32), .RST_PULSE_CYCLES(4)
    ) dut (
        .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .btn_db(btn_db),
        .btn_press(btn_press), .btn_release(btn_release),
        .sys_resetn(sys_resetn), .combo_hold(combo_hold)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        btn_raw = '0;
        tick(5);
        vecs++;
        if (sys_resetn !== 1'b0) begin
            errs++; $display("FAIL rst_sys_resetn: got %b want 0", sys_resetn);
        end
        vecs++;
        if ({btn_db, btn_press, btn_release, combo_hold} !== 13'b0) begin
            errs++; $display("FAIL rst_outputs: got %h want 0", {btn_db, btn_press, btn_release, combo_hold});
        end
        resetn = 1'b1;
        #1;
        vecs++;
        if (sys_resetn !== 1'b0) begin
            errs++; $display("FAIL rst_release_low: got %b want 0", sys_resetn);
        end
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            vecs++;
            if (sys_resetn !== (k >= 4)) begin
                errs++; $display("FAIL por_stretch k=%0d: got %b want %b", k, sys_resetn, k >= 4);
            end
            vecs++;
            if ({btn_db, btn_press, btn_release, combo_hold} !== 13'b0) begin
                errs++; $display("FAIL por_outputs k=%0d: got %h want 0", k, {btn_db, btn_press, btn_release, combo_hold});
            end
        end
    endtask

    task automatic test_clean_press;
        logic [NB-1:0] e_db, e_p, e_r;
        btn_raw = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            e_db = (k >= 10) ? 4'b0100 : 4'b0000;
            e_p  = (k == 10) ? 4'b0100 : 4'b0000;
            vecs++;
            if ({btn_db, btn_press, btn_release} !== {e_db, e_p, 4'b0000}) begin
                errs++; $display("FAIL press k=%0d: got db=%b p=%b r=%b want db=%b p=%b r=0000",
                                 k, btn_db, btn_press, btn_release, e_db, e_p);
            end
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            e_db = (k >= 10) ? 4'b0000 : 4'b0100;
            e_r  = (k == 10) ? 4'b0100 : 4'b0000;
            vecs++;
            if ({btn_db, btn_press, btn_release} !== {e_db, 4'b0000, e_r}) begin
                errs++; $display("FAIL release k=%0d: got db=%b p=%b r=%b want db=%b p=0000 r=%b",
                                 k, btn_db, btn_press, btn_release, e_db, e_r);
            end
        end
    endtask

    task automatic test_bounce;
        logic lvl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   len [4] = '{5, 2, 7, 12};
        int   presses = 0;
        for (int s = 0; s < 4; s++) begin
            btn_raw[3] = lvl[s];
            for (int j = 0; j < len[s]; j++) begin
                tick(1);
                vecs++;
                if ({btn_db, btn_press, btn_release} !== 12'b0) begin
                    errs++; $display("FAIL bounce seg=%0d j=%0d: got db=%b p=%b r=%b want 0",
                                     s, j, btn_db, btn_press, btn_release);
                end
            end
        end
        btn_raw[3] = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick(1);
            if (btn_press[3]) presses++;
        end
        vecs++;
        if (presses != 1) begin
            errs++; $display("FAIL bounce_presses: got %0d want 1", presses);
        end
        vecs++;
        if (btn_db !== 4'b1000) begin
            errs++; $display("FAIL bounce_db: got %b want 1000", btn_db);
        end
        btn_raw[3] = 1'b0;
        tick(12);
        vecs++;
        if (btn_db !== 4'b0000) begin
            errs++; $display("FAIL bounce_settle: got %b want 0000", btn_db);
        end
    endtask

    task automatic test_short_combo;
        int holds = 0;
        btn_raw = 4'b0011;
        for (int k = 1; k <= 60; k++) begin
            if (k == 21) btn_raw = 4'b0000;
            tick(1);
            if (combo_hold) holds++;
            vecs++;
            if (sys_resetn !== 1'b1) begin
                errs++; $display("FAIL short_sys_resetn k=%0d: got %b want 1", k, sys_resetn);
            end
        end
        vecs++;
        if (holds != 20) begin
            errs++; $display("FAIL short_hold_cycles: got %0d want 20", holds);
        end
        vecs++;
        if (combo_hold !== 1'b0) begin
            errs++; $display("FAIL short_hold_end: got %b want 0", combo_hold);
        end
    endtask

    task automatic test_long_combo;
        int nh [2] = '{200, 60};
        int holds, lows, falls;
        logic prev;
        for (int r = 0; r < 2; r++) begin
            holds = 0; lows = 0; falls = 0;
            prev = sys_resetn;
            btn_raw = 4'b0011;
            for (int k = 1; k <= nh[r] + 20; k++) begin
                if (k == nh[r] + 1) btn_raw = 4'b0000;
                tick(1);
                if (combo_hold) holds++;
                if (!sys_resetn) lows++;
                if (prev && !sys_resetn) falls++;
                prev = sys_resetn;
            end
            vecs++;
            if (holds != 32) begin
                errs++; $display("FAIL long%0d_hold_cycles: got %0d want 32", r, holds);
            end
            vecs++;
            if (lows != 4) begin
                errs++; $display("FAIL long%0d_low_cycles: got %0d want 4", r, lows);
            end
            vecs++;
            if (falls != 1) begin
                errs++; $display("FAIL long%0d_pulses: got %0d want 1", r, falls);
            end
            vecs++;
            if ({sys_resetn, combo_hold} !== 2'b10) begin
                errs++; $display("FAIL long%0d_end: got %b want 10", r, {sys_resetn, combo_hold});
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        int holds = 0;
        int rise = 0;
        btn_raw = 4'b0011;
        for (int k = 1; k <= 40 && holds < 15; k++) begin
            tick(1);
            if (combo_hold) holds++;
        end
        vecs++;
        if (holds != 15) begin
            errs++; $display("FAIL mid_reach_hold: got %0d want 15", holds);
        end
        resetn = 1'b0;
        #1;
        vecs++;
        if ({combo_hold, sys_resetn, btn_db} !== 6'b0) begin
            errs++; $display("FAIL mid_async: got hold=%b srn=%b db=%b want 0",
                             combo_hold, sys_resetn, btn_db);
        end
        btn_raw = 4'b0000;
        tick(3);
        resetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            vecs++;
            if (sys_resetn !== (k >= 4)) begin
                errs++; $display("FAIL mid_stretch k=%0d: got %b want %b", k, sys_resetn, k >= 4);
            end
        end
        btn_raw = 4'b0011;
        for (int k = 1; k <= 30 && rise == 0; k++) begin
            tick(1);
            if (combo_hold) rise = k;
        end
        vecs++;
        if (rise != 11) begin
            errs++; $display("FAIL mid_rehold_latency: got %0d want 11", rise);
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            vecs++;
            if (sys_resetn !== 1'b1) begin
                errs++; $display("FAIL mid_no_reset k=%0d: got %b want 1", k, sys_resetn);
            end
        end
        vecs++;
        if (combo_hold !== 1'b0) begin
            errs++; $display("FAIL mid_hold_end: got %b want 0", combo_hold);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_combo();
        test_long_combo();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Sits between the Boolean board push-buttons and the embedded system's button and reset inputs.
- Synchronises and debounces the four raw buttons.
- Produces one-cycle press and release pulses for each button.
- Generates the system active-low reset: stretched after power-on, and asserted when btn0 and btn1 are held together for a qualification time. Replaces the direct combinational btn0&btn1 reset.

Parameters:
NUM_BTN, 4, number of buttons conditioned (bit 0 = btn0 ... bit 3 = btn3)
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz)
RESET_HOLD_CYCLES, 50000000, cycles btn0 and btn1 (debounced) must both be held to trigger reset (0.5 s)
RST_PULSE_CYCLES, 16, cycles sys_resetn is driven low per reset event; must be >= 1

Ports:
clk  input  1  100 MHz system clock
resetn  input  1  asynchronous active-low reset
btn_raw  input  NUM_BTN  raw asynchronous button levels, active high
btn_db  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse on debounced 0->1
btn_release  output  NUM_BTN  one-cycle pulse on debounced 1->0
sys_resetn  output  1  active-low reset to the embedded system
combo_hold  output  1  high while the btn0+btn1 hold is being qualified

Behaviour:
- Reset: clk and resetn are the only clock and reset. resetn is asynchronous and active-low. While resetn=0:
  - synchroniser flops, btn_db, btn_press, btn_release, combo_hold and all counters = 0.
  - sys_resetn = 0; combo FSM is in ASSERT with its pulse counter cleared.
  - After resetn rises, the FSM completes ASSERT (power-on stretch).
- Synchroniser: two flops per bit. s2[i] reflects a btn_raw[i] change 2 clk edges after it is sampled.
- Debounce (per bit, independent counter sized ceil(log2(DEBOUNCE_CYCLES+1))):
  - Each cycle s2[i]==btn_db[i]: counter cleared.
  - Otherwise counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and s2[i]!=btn_db[i]: btn_db[i] toggles on the next edge and the counter clears.
  - A clean edge therefore appears on btn_db exactly 2+DEBOUNCE_CYCLES cycles after the raw change is sampled.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored entirely. Counter never wraps.
- Pulses: btn_press[i] / btn_release[i] are registered and high for exactly the first cycle in which btn_db[i] holds its new value; 0 otherwise. Bits are independent; simultaneous events on several bits all pulse.
- Combo FSM states:
  - WAIT: sys_resetn=1, combo_hold=0. Go to HOLD when btn_db[0]&btn_db[1]=1; hold counter cleared.
  - HOLD: combo_hold=1, hold counter increments each cycle.
    - If either bit drops: back to WAIT, counter cleared, no reset.
    - When counter==RESET_HOLD_CYCLES-1 with both still held: go to ASSERT.
  - ASSERT: sys_resetn=0 for exactly RST_PULSE_CYCLES cycles, combo_hold=0, then go to REARM.
  - REARM: sys_resetn=1. Go to WAIT only when btn_db[0]=0 and btn_db[1]=0, so one long hold produces exactly one reset pulse.
    - After power-on, REARM with both buttons released passes to WAIT in 1 cycle.
- sys_resetn is a registered output, glitch-free, and not combinationally derived from inputs.
- Button pulses continue to be generated normally during all combo states. Downstream firmware is held in reset during ASSERT.
- resetn low mid-HOLD or mid-debounce: immediate return to the reset state above. No partial count survives.
- btn2/btn3 never affect the combo FSM.

Test Plan:
(All scenarios run with DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=32, RST_PULSE_CYCLES=4.)
- Power-on: resetn low 5 cycles then high, btn_raw=0 -> sys_resetn=0 during reset and for 4 cycles after release, then 1. All other outputs remain 0.
- Clean press: btn_raw[2] 0->1 and held -> btn_db[2] rises 10 cycles after the sampling edge; btn_press[2] is high exactly 1 cycle. Release mirrors this with btn_release[2].
- Bounce: btn_raw[3] toggles high 5 cycles, low 2, high 7, low -> btn_db[3] stays 0, no pulses. Then high for 20 cycles -> exactly one press pulse.
- Short combo: btn0 and btn1 held 20 debounced cycles then released -> combo_hold high 20 cycles, sys_resetn stays 1.
- Long combo: btn0 and btn1 held 200 cycles -> after 32 cycles of combo_hold, sys_resetn=0 for exactly 4 cycles, once only. A second reset pulse occurs only after both are released and re-held for 32 cycles.
- Reset mid-HOLD: assert resetn low at cycle 15 of HOLD -> combo_hold=0 and sys_resetn=0 immediately. After release with buttons up: 4-cycle stretch, then normal operation.
